// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU.
// Ports:
//   clk, rst                 clock, async active-high reset
//   reqN_valid/ready         requester handshakes
//   reqN_a/b/op              operands and opcode
//   alu_a/b/op/en, alu_d     shared ALU drive and result
//   rsp_valid/ready/id/data  response handshake
//   busy, done_cnt           status, completions
module alu_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req1_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_en,
  input  logic [15:0]      alu_d,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic             last;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [3:0]       op_q;
  logic             id_q;
  logic [15:0]      res_q;
  logic [CNT_W-1:0] cnt_q;

  logic grant;
  logic pick1;

  // Requester 1 wins when it is alone, or on a tie
  // when requester 0 was granted last.
  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    pick1      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          pick1      = req1_valid &
                       (~req0_valid | ~last);
          grant      = 1'b1;
          req0_ready = ~pick1;
          req1_ready = pick1;
          state_nx   = EXEC;
        end
      end
      EXEC: begin
        state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      id_q  <= 1'b0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        a_q  <= pick1 ? req1_a : req0_a;
        b_q  <= pick1 ? req1_b : req0_b;
        op_q <= pick1 ? req1_op : req0_op;
        id_q <= pick1;
        last <= pick1;
      end
      if (state == EXEC) begin
        res_q <= alu_d;
      end
      if (state == RESP && rsp_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_en    = (state == EXEC);
  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = res_q;
  assign busy      = (state != IDLE);
  assign done_cnt  = cnt_q;

endmodule
